// File: rtl/conv_pkg.sv
// Shared constants for the partial-sum accumulator: default datum format,
// window-length width and FSM state encoding.
package conv_pkg;

  localparam int unsigned N_DEF     = 32;
  localparam int unsigned Q_DEF     = 15;
  localparam int unsigned LEN_W_DEF = 8;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_ACC  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/psum_accum_if.sv
// Input-term and window-sum handshake bundle for psum_accum.
interface psum_accum_if
  import conv_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic [LEN_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_ovf;

  modport master (
    output cfg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  cfg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/psum_sat_add.sv
// Signed N-bit adder with overflow detect. Build with PSUM_SAT_EN defined to
// clamp the sum on overflow; otherwise the sum wraps modulo 2^N.
module psum_sat_add #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  logic [N-1:0] raw;

  assign raw = a + b;
  // Same-sign operands producing an opposite-sign result.
  assign ovf = (a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]);

`ifdef PSUM_SAT_EN
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  assign sum = ovf ? (a[N-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/psum_accum.sv
// Windowed signed partial-sum accumulator (IDLE/ACC/DONE). Saturating build
// selected by PSUM_SAT_EN inside psum_sat_add.
module psum_accum
  import conv_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  psum_accum_if.slave bus
);

  if (Q >= N) begin : g_bad_q
    $error("psum_accum: Q must be smaller than N");
  end

  logic [ST_W-1:0]  state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [N-1:0]     add_sum;
  logic             add_ovf;
  logic             beat_c;
  logic [LEN_W-1:0] cnt_inc_c;
  logic [LEN_W-1:0] len_in_c;

  psum_sat_add #(.N(N)) u_add (
    .a   (acc_q),
    .b   (bus.in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign beat_c    = bus.in_valid & in_ready_q;
  assign cnt_inc_c = cnt_q + LEN_W'(1);
  // A zero window length is treated as a single-term window.
  assign len_in_c  = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (beat_c) begin
          len_d   = len_in_c;
          acc_d   = bus.in_data;
          ovf_d   = 1'b0;
          cnt_d   = LEN_W'(1);
          state_d = (len_in_c == LEN_W'(1)) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (beat_c) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // The accumulator is held unchanged in DONE, so it doubles as the output register.
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_accum.sv
// Scoreboard bench for psum_accum: directed windows push expected sums, a
// negedge monitor checks every output handshake against the queue.
module tb_psum_accum;
  import conv_pkg::*;

  localparam int unsigned N     = 32;
  localparam int unsigned LEN_W = 8;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  psum_accum_if #(.N(N), .LEN_W(LEN_W)) bus ();

  psum_accum #(.N(N), .Q(15), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for data 0x%08h", d);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && !bus.out_valid; i++) tick();
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: out_valid never asserted");
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Monitor: a handshake completes at the next posedge when valid & ready here.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%08h with empty scoreboard", bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_ovf", 32'(bus.out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1.0 + 0.5 - 0.5 over three back-to-back beats
    bus.cfg_len = 8'd3;
    push(32'h0000_8000, 1'b0);
    send(32'h0000_8000);
    send(32'h0000_4000);
    chk("w3_not_early", 32'(bus.out_valid), 32'd0);
    send(32'hFFFF_C000);
    chk("w3_latency", 32'(bus.out_valid), 32'd1);
    drain();

    // Zero length behaves as one term
    bus.cfg_len = 8'd0;
    push(32'h1234_5678, 1'b0);
    send(32'h1234_5678);
    chk("len0_latency", 32'(bus.out_valid), 32'd1);
    chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
    drain();

    // Positive overflow
    bus.cfg_len = 8'd2;
`ifdef PSUM_SAT_EN
    push(32'h7FFF_FFFF, 1'b1);
`else
    push(32'h8000_0000, 1'b1);
`endif
    send(32'h7FFF_FFFF);
    send(32'h0000_0001);
    drain();

    // Negative overflow, then keep accumulating from the clamped/wrapped value
    bus.cfg_len = 8'd3;
`ifdef PSUM_SAT_EN
    push(32'h8000_0005, 1'b1);
`else
    push(32'h8000_0004, 1'b1);
`endif
    send(32'h8000_0000);
    send(32'hFFFF_FFFF);
    send(32'h0000_0005);
    drain();

    // Gapped window, cfg_len changed mid-window, back-pressure in DONE
    bus.cfg_len = 8'd4;
    push(32'h0000_0250, 1'b0);
    send(32'h0000_0100);
    bus.cfg_len = 8'd1;
    tick();
    tick();
    send(32'h0000_0200);
    tick();
    send(32'hFFFF_FF00);
    repeat (3) tick();
    send(32'h0000_0050);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_7777;
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", bus.out_data, 32'h0000_0250);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();
    bus.cfg_len = 8'd2;
    push(32'h0000_0030, 1'b0);
    send(32'h0000_0010);
    send(32'h0000_0020);
    drain();

    // Reset mid-window discards the partial sum
    bus.cfg_len = 8'd4;
    send(32'h0000_1000);
    send(32'h0000_2000);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_acc", bus.out_data, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.cfg_len = 8'd2;
    push(32'h0000_0020, 1'b0);
    send(32'h0000_0010);
    send(32'h0000_0010);
    drain();

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d expected outputs never seen", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameter N, default 32, total word width of the signed fixed-point datum.
REQ-002 Parameter Q, default 15, number of fractional bits; it carries no arithmetic effect and is declared for format consistency with the adder stage.
REQ-003 Parameter LEN_W, default 8, width of the window-length field.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cfg_len  input  LEN_W  number of terms per window; sampled only on the first accepted beat of a window.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  N  signed Q-format product term.
REQ-010 out_valid  output  1  out_data holds a completed window sum.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  N  signed Q-format window sum.
REQ-013 out_ovf  output  1  sticky flag: overflow occurred in this window; valid with out_valid.

Function
REQ-014 The block SHALL be an FSM with states IDLE, ACC and DONE.
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-017 On an accepted beat in IDLE, the block SHALL:
- latch cfg_len into len_q, treating 0 as 1;
- load acc with in_data, clear ovf and set cnt to 1;
- go to DONE if len_q==1, otherwise go to ACC.
REQ-018 On an accepted beat in ACC, the block SHALL set acc to acc+in_data (N-bit signed), increment cnt, and go to DONE when the new cnt equals len_q.
REQ-019 Overflow SHALL be detected when both addends have the same sign and the sum sign differs; ovf SHALL then be set and remain set until the next window starts.
REQ-020 In DONE, out_valid SHALL be 1 and out_data/out_ovf SHALL hold stable until out_ready is 1.
REQ-021 On the DONE handshake, the block SHALL go to IDLE; no input beat SHALL be accepted in that cycle.
REQ-022 Latency SHALL be one cycle from the last accepted beat to out_valid=1.
REQ-023 Peak throughput SHALL be len_q+1 cycles per window.
REQ-024 A cfg_len change mid-window SHALL have no effect on the current window.
REQ-025 Cycles in ACC with in_valid=0 SHALL leave acc, cnt and ovf unchanged.

Reset
REQ-026 When rst_n=0, the block SHALL immediately set: state to IDLE, acc, cnt, len_q and ovf to 0, out_valid to 0, out_data to 0, out_ovf to 0, and in_ready to 1 after release.
REQ-027 Assertion of reset mid-window or in DONE SHALL discard the partial or pending sum without producing any output.

Configuration
REQ-028 With PSUM_SAT_EN defined, on overflow the sum SHALL clamp to 2^(N-1)-1 for positive operands and -2^(N-1) for negative operands; subsequent terms SHALL accumulate from the clamped value.
REQ-029 Without PSUM_SAT_EN, the sum SHALL wrap modulo 2^N.
REQ-030 out_ovf behaviour SHALL be identical in both builds.

Structure
REQ-031 A shared package conv_pkg SHALL hold the default N, Q and LEN_W constants and the FSM state encoding.
REQ-032 The overflow-detect/saturate adder SHALL be a sub-module psum_sat_add (combinational, a, b -> sum, ovf); the PSUM_SAT_EN selection SHALL be confined to it.

Verification
REQ-033 cfg_len=3; terms 0x00008000, 0x00004000, 0xFFFFC000 (1.0, 0.5, -0.5) back-to-back -> out_valid one cycle after the third beat, out_data=0x00008000, out_ovf=0.
REQ-034 cfg_len=0; single term 0x12345678 -> treated as length 1, out_data=0x12345678 in DONE on the next cycle.
REQ-035 cfg_len=2; terms 0x7FFFFFFF, 0x00000001:
- PSUM_SAT_EN defined -> out_data=0x7FFFFFFF, out_ovf=1;
- PSUM_SAT_EN undefined -> out_data=0x80000000, out_ovf=1.
REQ-036 cfg_len=4 with in_valid gaps; out_ready held 0 for 5 cycles in DONE -> in_ready=0 and out_data stable throughout; the next window's sum is unaffected by the previous one.
REQ-037 Assert rst_n=0 after 2 of 4 beats -> out_valid stays 0; a fresh 2-term window of 0x00000010 each -> out_data=0x00000020.
